gbufce_seq_ctrl: RTL and testbench

Clock-enable sequencer for a bank of glitch-free gated global clock buffers. It owns the CE input of up to NUM_DOM buffers, one per clock domain. It turns each domain's clock on when that domain requests it and turns it off after a programmable idle period. It allows at most one CE transition per WAKE_GAP cycles, which limits supply di/dt. It sits on the always-on clock next to the buffer bank, between power-management requesters and the buffers.

---
 rtl/gbufce_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_gbufce_seq_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gbufce_seq_ctrl.sv
// Clock-enable sequencer for a bank of gated global clock buffers.
// Wakes domains on request, sleeps them after an idle period, and spaces CE edges by WAKE_GAP.
module gbufce_seq_ctrl #(
  parameter int   NUM_DOM       = 4,
  parameter int   IDLE_CYCLES   = 16,
  parameter int   SETTLE_CYCLES = 2,
  parameter int   WAKE_GAP      = 2,
  parameter logic CE_POLARITY   = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_DOM-1:0] req_i,
  input  logic [NUM_DOM-1:0] act_i,
  output logic [NUM_DOM-1:0] ce_o,
  output logic [NUM_DOM-1:0] gnt_o,
  output logic               busy_o
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int GW = (WAKE_GAP > 1) ? $clog2(WAKE_GAP) : 1;
  localparam int PW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LD    = GW'(WAKE_GAP - 1);

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;

  logic [NUM_DOM-1:0][1:0]    state_q, state_d;
  logic [NUM_DOM-1:0][IW-1:0] idle_q, idle_d;
  logic [NUM_DOM-1:0][SW-1:0] settle_q, settle_d;
  logic [NUM_DOM-1:0]         ce_q, ce_d;
  logic [NUM_DOM-1:0]         gnt_q, gnt_d;
  logic [GW-1:0]              gap_q, gap_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic                       busy_q, busy_d;

  logic [NUM_DOM-1:0] pend_on, pend_off;
  logic [PW:0]        on_pick, off_pick;
  logic               slot_free, grant_on, grant_off;
  logic [PW-1:0]      grant_idx;

  // Round-robin search from ptr; returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NUM_DOM-1:0] pend,
                                          input logic [PW-1:0] ptr);
    logic          found;
    logic [PW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_DOM; k++) begin
      j = (int'(ptr) + k) % NUM_DOM;
      if (!found && pend[j]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    pend_on  = '0;
    pend_off = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      pend_on[i]  = (state_q[i] == ST_OFF) && req_i[i];
      pend_off[i] = (state_q[i] == ST_ON) && !req_i[i] && (idle_q[i] == IDLE_MAX);
    end
  end

  always_comb begin
    on_pick   = rr_pick(pend_on, ptr_q);
    off_pick  = rr_pick(pend_off, ptr_q);
    slot_free = (gap_q == '0);
    // Wake requests always take the slot ahead of sleep requests.
    grant_on  = slot_free && on_pick[PW];
    grant_off = slot_free && !on_pick[PW] && off_pick[PW];
    grant_idx = on_pick[PW] ? on_pick[PW-1:0] : off_pick[PW-1:0];

    gap_d = gap_q;
    ptr_d = ptr_q;
    if (grant_on || grant_off) begin
      gap_d = GAP_LD;
      ptr_d = (int'(grant_idx) == NUM_DOM - 1) ? '0 : grant_idx + PW'(1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end

    state_d  = state_q;
    idle_d   = idle_q;
    settle_d = settle_q;
    ce_d     = ce_q;
    gnt_d    = gnt_q;
    for (int i = 0; i < NUM_DOM; i++) begin
      case (state_q[i])
        ST_OFF: begin
          if (grant_on && (int'(grant_idx) == i)) begin
            state_d[i]  = ST_SETTLE;
            settle_d[i] = SETTLE_LD;
            ce_d[i]     = CE_POLARITY;
          end
        end
        ST_SETTLE: begin
          if (settle_q[i] == '0) begin
            state_d[i] = ST_ON;
            gnt_d[i]   = 1'b1;
            idle_d[i]  = '0;
          end else begin
            settle_d[i] = settle_q[i] - SW'(1);
          end
        end
        ST_ON: begin
          if (grant_off && (int'(grant_idx) == i)) begin
            state_d[i] = ST_OFF;
            ce_d[i]    = ~CE_POLARITY;
            gnt_d[i]   = 1'b0;
            idle_d[i]  = '0;
          end else if (req_i[i] || act_i[i]) begin
            idle_d[i] = '0;
          end else if (idle_q[i] != IDLE_MAX) begin
            idle_d[i] = idle_q[i] + IW'(1);
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          ce_d[i]    = ~CE_POLARITY;
          gnt_d[i]   = 1'b0;
          idle_d[i]  = '0;
        end
      endcase
    end

    // BUSY is registered, so it is evaluated against the post-edge state.
    busy_d = (gap_d != '0);
    for (int i = 0; i < NUM_DOM; i++) begin
      if ((state_d[i] == ST_SETTLE) ||
          ((state_d[i] == ST_OFF) && req_i[i]) ||
          ((state_d[i] == ST_ON) && !req_i[i] && (idle_d[i] == IDLE_MAX)))
        busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= '0;
      idle_q   <= '0;
      settle_q <= '0;
      ce_q     <= {NUM_DOM{~CE_POLARITY}};
      gnt_q    <= '0;
      gap_q    <= '0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      settle_q <= settle_d;
      ce_q     <= ce_d;
      gnt_q    <= gnt_d;
      gap_q    <= gap_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign ce_o   = ce_q;
  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_gbufce_seq_ctrl.sv
// Directed bench for gbufce_seq_ctrl: one default instance and one with inverted CE polarity.
module tb_gbufce_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, rst_n_p;
  logic [3:0] req, act, req_p, act_p;
  logic [3:0] ce, gnt, ce_p, gnt_p;
  logic       busy, busy_p;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  gbufce_seq_ctrl #(
    .NUM_DOM(4), .IDLE_CYCLES(16), .SETTLE_CYCLES(2), .WAKE_GAP(2), .CE_POLARITY(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .act_i(act),
    .ce_o(ce), .gnt_o(gnt), .busy_o(busy)
  );

  gbufce_seq_ctrl #(
    .NUM_DOM(4), .IDLE_CYCLES(16), .SETTLE_CYCLES(2), .WAKE_GAP(2), .CE_POLARITY(1'b0)
  ) u_dut_p0 (
    .clk_i(clk), .rst_n_i(rst_n_p), .req_i(req_p), .act_i(act_p),
    .ce_o(ce_p), .gnt_o(gnt_p), .busy_o(busy_p)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    act   = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst_n_p = 1'b0;
    req = '0; act = '0; req_p = '0; act_p = '0;
    tick(2);
    check_eq("rst_ce", ce, 4'h0);
    check_eq("rst_gnt", gnt, 4'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ce_p0", ce_p, 4'hF);
    check_eq("rst_gnt_p0", gnt_p, 4'h0);
    rst_n = 1'b1; rst_n_p = 1'b1;
    tick(1);
    check_eq("idle_ce", ce, 4'h0);
    check_eq("idle_busy", busy, 1'b0);

    // Single wake of domain 1
    req = 4'b0010;
    tick(1);
    check_eq("w1_ce_e0", ce, 4'b0010);
    check_eq("w1_gnt_e0", gnt, 4'b0000);
    check_eq("w1_busy_e0", busy, 1'b1);
    tick(1);
    check_eq("w1_gnt_e1", gnt, 4'b0000);
    check_eq("w1_busy_e1", busy, 1'b1);
    tick(1);
    check_eq("w1_gnt_e2", gnt, 4'b0010);
    check_eq("w1_busy_e2", busy, 1'b0);

    // Simultaneous wake of all domains
    do_reset();
    req = 4'b1111;
    tick(1); check_eq("sw_ce_e0", ce, 4'b0001);
    tick(1); check_eq("sw_ce_e1", ce, 4'b0001);
    tick(1); check_eq("sw_ce_e2", ce, 4'b0011);
    tick(1); check_eq("sw_ce_e3", ce, 4'b0011);
    tick(1); check_eq("sw_ce_e4", ce, 4'b0111);
    tick(2); check_eq("sw_ce_e6", ce, 4'b1111);
    tick(1); check_eq("sw_gnt_e7", gnt, 4'b0111);
    tick(1); check_eq("sw_gnt_e8", gnt, 4'b1111);
    check_eq("sw_busy_e8", busy, 1'b0);

    // Idle sleep of domain 0: last high edge is m
    tick(1);
    req = 4'b1110;
    tick(16);
    check_eq("sl_ce_m16", ce, 4'b1111);
    check_eq("sl_gnt_m16", gnt, 4'b1111);
    check_eq("sl_busy_m16", busy, 1'b1);
    tick(1);
    check_eq("sl_ce_m17", ce, 4'b1110);
    check_eq("sl_gnt_m17", gnt, 4'b1110);

    // Keep-alive via ACT pulses
    req = 4'b1111;
    tick(5);
    check_eq("ka_gnt_up", gnt, 4'b1111);
    req = 4'b1110;
    for (int c = 0; c < 60; c++) begin
      act = (c % 10 == 9) ? 4'b0001 : 4'b0000;
      tick(1);
    end
    act = '0;
    check_eq("ka_ce", ce, 4'b1111);
    check_eq("ka_gnt", gnt, 4'b1111);

    // Cancel: REQ re-raised exactly when idle saturates
    tick(16);
    check_eq("cn_ce_m16", ce, 4'b1111);
    req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      check_eq("cn_ce", ce, 4'b1111);
      check_eq("cn_gnt", gnt, 4'b1111);
    end

    // Contention: pending-off 2 vs pending-on 3 with ptr at 2
    do_reset();
    req = 4'b0100;
    tick(3);
    check_eq("ct_gnt2", gnt, 4'b0100);
    req = 4'b0110;
    tick(3);
    check_eq("ct_gnt12", gnt, 4'b0110);
    req = 4'b0010;
    tick(16);
    check_eq("ct_ce_m16", ce, 4'b0110);
    req = 4'b1010;
    tick(1);
    check_eq("ct_ce_m17", ce, 4'b1110);
    check_eq("ct_gnt_m17", gnt, 4'b0110);
    tick(1);
    check_eq("ct_ce_m18", ce, 4'b1110);
    tick(1);
    check_eq("ct_ce_m19", ce, 4'b1010);
    check_eq("ct_gnt_m19", gnt, 4'b1010);

    // Inverted polarity with reset pulsed mid-settle
    req_p = 4'b0001;
    tick(1);
    check_eq("p0_ce_e0", ce_p, 4'b1110);
    tick(1);
    check_eq("p0_gnt_e1", gnt_p, 4'b0000);
    check_eq("p0_busy_e1", busy_p, 1'b1);
    #3 rst_n_p = 1'b0;
    #1;
    check_eq("p0_async_ce", ce_p, 4'b1111);
    check_eq("p0_async_gnt", gnt_p, 4'b0000);
    check_eq("p0_async_busy", busy_p, 1'b0);
    req_p = '0;
    tick(1);
    check_eq("p0_hold_ce", ce_p, 4'b1111);
    rst_n_p = 1'b1;
    tick(1);
    check_eq("p0_rel_ce", ce_p, 4'b1111);
    req_p = 4'b0001;
    tick(1);
    check_eq("p0_rw_ce", ce_p, 4'b1110);
    check_eq("p0_rw_gnt0", gnt_p, 4'b0000);
    tick(1);
    check_eq("p0_rw_gnt1", gnt_p, 4'b0000);
    tick(1);
    check_eq("p0_rw_gnt2", gnt_p, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
